// File: rtl/regfile_pkg.sv
// Shared constants for the Beta-style register file: default width, depth
// and the indices of the architecturally special registers.
package regfile_pkg;

    localparam int DATA_W_DEF   = 32;
    localparam int NREGS_DEF    = 32;
    localparam int ZERO_REG_IDX = 31;
    localparam int XP_REG_IDX   = 30;
    localparam int SP_REG_IDX   = 29;
    localparam int LP_REG_IDX   = 28;
    localparam int BP_REG_IDX   = 27;

endpackage

// File: rtl/regfile_scoreboard.sv
// One busy bit per register: set by decode when a producer issues,
// cleared by writeback, with two combinational lookups.
module regfile_scoreboard
    import regfile_pkg::*;
#(
    parameter int NREGS    = NREGS_DEF,
    parameter int ZERO_REG = ZERO_REG_IDX
) (
    input  logic                     clock,
    input  logic                     reset_n,
    input  logic                     clr_en,
    input  logic [$clog2(NREGS)-1:0] clr_addr,
    input  logic                     rsv_en,
    input  logic [$clog2(NREGS)-1:0] rsv_addr,
    input  logic [$clog2(NREGS)-1:0] look_a,
    input  logic [$clog2(NREGS)-1:0] look_b,
    output logic                     busy_a,
    output logic                     busy_b
);

    localparam int AW = $clog2(NREGS);
    localparam logic [AW-1:0] ZERO_A = AW'(ZERO_REG);

    logic [NREGS-1:0] busy;

    // The reserve assignment comes last so a same-cycle reserve overrides
    // the clear: the newly issued producer is still outstanding.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            busy <= '0;
        end else begin
            if (clr_en && (clr_addr != ZERO_A)) busy[clr_addr] <= 1'b0;
            if (rsv_en && (rsv_addr != ZERO_A)) busy[rsv_addr] <= 1'b1;
        end
    end

    assign busy_a = busy[look_a];
    assign busy_b = busy[look_b];

endmodule

// File: rtl/regfile_bypass_sb.sv
// Two-read / one-write register file with hardwired zero register, XP write
// override, optional write-to-read bypass and a busy scoreboard.
module regfile_bypass_sb
    import regfile_pkg::*;
#(
    parameter int DATA_W   = DATA_W_DEF,
    parameter int NREGS    = NREGS_DEF,
    parameter int ZERO_REG = ZERO_REG_IDX,
    parameter int XP_REG   = XP_REG_IDX,
    parameter bit BYPASS   = 1'b1
) (
    input  logic                     clock,
    input  logic                     reset_n,
    input  logic [$clog2(NREGS)-1:0] ra,
    input  logic [$clog2(NREGS)-1:0] rb,
    input  logic [$clog2(NREGS)-1:0] rc,
    input  logic                     ra2sel,
    input  logic                     wasel,
    input  logic                     werf,
    input  logic [DATA_W-1:0]        wdata,
    input  logic                     rsv_en,
    input  logic [$clog2(NREGS)-1:0] rsv_addr,
    output logic [DATA_W-1:0]        radata,
    output logic [DATA_W-1:0]        rbdata,
    output logic                     busy_a,
    output logic                     busy_b
);

    localparam int AW = $clog2(NREGS);
    localparam logic [AW-1:0] ZERO_A = AW'(ZERO_REG);
    localparam logic [AW-1:0] XP_A   = AW'(XP_REG);

    logic [DATA_W-1:0] regs [NREGS];
    logic [AW-1:0]     addr_b;
    logic [AW-1:0]     wa;
    logic              we;
    logic              sb_busy_a;
    logic              sb_busy_b;
    logic [DATA_W:0]   port_a;
    logic [DATA_W:0]   port_b;

    assign addr_b = ra2sel ? rc : rb;
    assign wa     = wasel ? XP_A : rc;
    assign we     = werf && (wa != ZERO_A);

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < NREGS; i++) regs[i] <= '0;
        end else if (we) begin
            regs[wa] <= wdata;
        end
    end

    regfile_scoreboard #(
        .NREGS    (NREGS),
        .ZERO_REG (ZERO_REG)
    ) u_scoreboard (
        .clock    (clock),
        .reset_n  (reset_n),
        .clr_en   (werf),
        .clr_addr (wa),
        .rsv_en   (rsv_en),
        .rsv_addr (rsv_addr),
        .look_a   (ra),
        .look_b   (addr_b),
        .busy_a   (sb_busy_a),
        .busy_b   (sb_busy_b)
    );

    // Returns {data, busy}; a forwarded value is the producer's result, so
    // the reader no longer has to wait for it.
    function automatic logic [DATA_W:0] read_port(
        input logic [AW-1:0]     addr,
        input logic [DATA_W-1:0] stored,
        input logic              sb_busy,
        input logic              wr_en,
        input logic [AW-1:0]     wr_addr,
        input logic [DATA_W-1:0] wr_data
    );
        if (addr == ZERO_A) return '0;
        if (BYPASS && wr_en && (wr_addr == addr)) return {wr_data, 1'b0};
        return {stored, sb_busy};
    endfunction

    assign port_a = read_port(ra, regs[ra], sb_busy_a, we, wa, wdata);
    assign port_b = read_port(addr_b, regs[addr_b], sb_busy_b, we, wa, wdata);

    // Outputs are forced quiet during reset so a bypassed wdata cannot leak out.
    assign {radata, busy_a} = reset_n ? port_a : '0;
    assign {rbdata, busy_b} = reset_n ? port_b : '0;

endmodule

// File: tb/tb_regfile_bypass_sb.sv
// Directed bench for regfile_bypass_sb: a per-cycle vector table plus
// hand-written sequences for the non-bypass variant and mid-run reset.
module tb_regfile_bypass_sb;

    localparam int DW = 32;
    localparam int AW = 5;

    typedef struct {
        logic [AW-1:0] ra, rb, rc;
        logic          ra2sel, wasel, werf;
        logic [DW-1:0] wdata;
        logic          rsv_en;
        logic [AW-1:0] rsv_addr;
        logic [DW-1:0] e_ra, e_rb;
        logic          e_ba, e_bb;
    } vec_t;

    logic          clock;
    logic          reset_n;
    logic [AW-1:0] ra, rb, rc, rsv_addr;
    logic          ra2sel, wasel, werf, rsv_en;
    logic [DW-1:0] wdata;
    logic [DW-1:0] radata, rbdata, nb_radata, nb_rbdata;
    logic          busy_a, busy_b, nb_busy_a, nb_busy_b;

    int n_checks = 0;
    int n_fail   = 0;
    vec_t tbl [30];

    regfile_bypass_sb #(.BYPASS(1'b1)) dut (
        .clock(clock), .reset_n(reset_n), .ra(ra), .rb(rb), .rc(rc),
        .ra2sel(ra2sel), .wasel(wasel), .werf(werf), .wdata(wdata),
        .rsv_en(rsv_en), .rsv_addr(rsv_addr), .radata(radata),
        .rbdata(rbdata), .busy_a(busy_a), .busy_b(busy_b)
    );

    regfile_bypass_sb #(.BYPASS(1'b0)) dut_nb (
        .clock(clock), .reset_n(reset_n), .ra(ra), .rb(rb), .rc(rc),
        .ra2sel(ra2sel), .wasel(wasel), .werf(werf), .wdata(wdata),
        .rsv_en(rsv_en), .rsv_addr(rsv_addr), .radata(nb_radata),
        .rbdata(nb_rbdata), .busy_a(nb_busy_a), .busy_b(nb_busy_b)
    );

    // clock / reset
    initial clock = 1'b0;
    always #5 clock = ~clock;

    function automatic vec_t mk(
        input logic [AW-1:0] a, b, c, input logic a2s, was, we,
        input logic [DW-1:0] wd, input logic rs, input logic [AW-1:0] rsa,
        input logic [DW-1:0] ea, eb, input logic eba, ebb
    );
        vec_t v;
        v.ra = a; v.rb = b; v.rc = c; v.ra2sel = a2s; v.wasel = was;
        v.werf = we; v.wdata = wd; v.rsv_en = rs; v.rsv_addr = rsa;
        v.e_ra = ea; v.e_rb = eb; v.e_ba = eba; v.e_bb = ebb;
        return v;
    endfunction

    task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic drive(input vec_t v);
        ra = v.ra; rb = v.rb; rc = v.rc; ra2sel = v.ra2sel; wasel = v.wasel;
        werf = v.werf; wdata = v.wdata; rsv_en = v.rsv_en; rsv_addr = v.rsv_addr;
    endtask

    task automatic idle();
        drive(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    endtask

    task automatic next_cycle();
        @(posedge clock);
        #1;
    endtask

    initial begin
        // fields: ra rb rc ra2sel wasel werf wdata rsv_en rsv_addr | radata rbdata busy_a busy_b
        tbl[0]  = mk(0, 1, 0, 0, 0, 0, 0, 0, 0,                    0, 0, 0, 0);
        tbl[1]  = mk(5, 5, 5, 0, 0, 1, 32'hDEAD, 0, 0,             32'hDEAD, 32'hDEAD, 0, 0);
        tbl[2]  = mk(5, 0, 0, 0, 0, 0, 0, 0, 0,                    32'hDEAD, 0, 0, 0);
        tbl[3]  = mk(31, 31, 31, 0, 0, 1, 32'hFFFF_FFFF, 0, 0,     0, 0, 0, 0);
        tbl[4]  = mk(31, 0, 0, 0, 0, 0, 0, 1, 31,                  0, 0, 0, 0);
        tbl[5]  = mk(31, 31, 0, 0, 0, 0, 0, 0, 0,                  0, 0, 0, 0);
        tbl[6]  = mk(30, 3, 3, 0, 1, 1, 32'h1234, 0, 0,            32'h1234, 0, 0, 0);
        tbl[7]  = mk(30, 3, 0, 0, 0, 0, 0, 0, 0,                   32'h1234, 0, 0, 0);
        tbl[8]  = mk(0, 0, 7, 0, 0, 1, 32'h11, 0, 0,               0, 0, 0, 0);
        tbl[9]  = mk(7, 7, 7, 0, 0, 1, 32'h22, 0, 0,               32'h22, 32'h22, 0, 0);
        tbl[10] = mk(7, 0, 0, 0, 0, 0, 0, 0, 0,                    32'h22, 0, 0, 0);
        tbl[11] = mk(9, 0, 0, 0, 0, 0, 0, 1, 9,                    0, 0, 0, 0);
        tbl[12] = mk(9, 9, 0, 0, 0, 0, 0, 0, 0,                    0, 0, 1, 1);
        tbl[13] = mk(9, 9, 9, 0, 0, 1, 32'h99, 0, 0,               32'h99, 32'h99, 0, 0);
        tbl[14] = mk(9, 0, 0, 0, 0, 0, 0, 0, 0,                    32'h99, 0, 0, 0);
        tbl[15] = mk(9, 0, 9, 0, 0, 1, 32'h55, 1, 9,               32'h55, 0, 0, 0);
        tbl[16] = mk(9, 9, 0, 0, 0, 0, 0, 0, 0,                    32'h55, 32'h55, 1, 1);
        tbl[17] = mk(9, 0, 0, 0, 0, 0, 0, 1, 9,                    32'h55, 0, 1, 0);
        tbl[18] = mk(9, 0, 0, 0, 0, 0, 0, 0, 0,                    32'h55, 0, 1, 0);
        tbl[19] = mk(0, 0, 4, 0, 0, 1, 32'hA, 0, 0,                0, 0, 0, 0);
        tbl[20] = mk(0, 0, 6, 0, 0, 1, 32'hB, 0, 0,                0, 0, 0, 0);
        tbl[21] = mk(6, 6, 4, 1, 0, 0, 0, 0, 0,                    32'hB, 32'hA, 0, 0);
        tbl[22] = mk(4, 6, 4, 0, 0, 0, 0, 0, 0,                    32'hA, 32'hB, 0, 0);
        tbl[23] = mk(4, 0, 4, 0, 0, 1, 32'hC, 0, 0,                32'hC, 0, 0, 0);
        tbl[24] = mk(4, 0, 0, 0, 0, 0, 0, 0, 0,                    32'hC, 0, 0, 0);
        tbl[25] = mk(12, 0, 12, 1, 0, 1, 32'h77, 0, 0,             32'h77, 32'h77, 0, 0);
        tbl[26] = mk(30, 0, 12, 1, 1, 1, 32'h5, 0, 0,              32'h5, 32'h77, 0, 0);
        tbl[27] = mk(12, 30, 0, 0, 0, 0, 0, 1, 12,                 32'h77, 32'h5, 0, 0);
        tbl[28] = mk(12, 12, 0, 0, 1, 1, 32'h6, 0, 0,              32'h77, 32'h77, 1, 1);
        tbl[29] = mk(30, 12, 0, 0, 0, 0, 0, 0, 0,                  32'h6, 32'h77, 0, 1);

        // reset: outputs quiet even with a would-be bypass presented
        reset_n = 1'b0;
        drive(mk(3, 3, 3, 0, 0, 1, 32'hABCD, 1, 3, 0, 0, 0, 0));
        #2;
        check("rst radata", radata, 0);
        check("rst rbdata", rbdata, 0);
        check("rst busy_a", {31'd0, busy_a}, 0);
        check("rst busy_b", {31'd0, busy_b}, 0);
        idle();
        repeat (2) @(posedge clock);
        @(negedge clock);
        reset_n = 1'b1;
        next_cycle();

        // vector table: outputs checked before the committing edge
        for (int i = 0; i < 30; i++) begin
            drive(tbl[i]);
            @(negedge clock);
            check($sformatf("row%0d radata", i), radata, tbl[i].e_ra);
            check($sformatf("row%0d rbdata", i), rbdata, tbl[i].e_rb);
            check($sformatf("row%0d busy_a", i), {31'd0, busy_a}, {31'd0, tbl[i].e_ba});
            check($sformatf("row%0d busy_b", i), {31'd0, busy_b}, {31'd0, tbl[i].e_bb});
            next_cycle();
        end

        // BYPASS=0 instance: old value and busy until the next cycle (r7=0x22)
        drive(mk(7, 7, 7, 0, 0, 1, 32'h33, 0, 0, 0, 0, 0, 0));
        @(negedge clock);
        check("byp radata", radata, 32'h33);
        check("nobyp radata", nb_radata, 32'h22);
        check("nobyp rbdata", nb_rbdata, 32'h22);
        next_cycle();
        drive(mk(7, 0, 0, 0, 0, 0, 0, 1, 7, 0, 0, 0, 0));
        @(negedge clock);
        check("nobyp after write", nb_radata, 32'h33);
        next_cycle();
        drive(mk(7, 0, 7, 0, 0, 1, 32'h44, 0, 0, 0, 0, 0, 0));
        @(negedge clock);
        check("byp busy_a", {31'd0, busy_a}, 0);
        check("nobyp busy_a", {31'd0, nb_busy_a}, 1);
        check("nobyp old data", nb_radata, 32'h33);
        next_cycle();
        drive(mk(7, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        @(negedge clock);
        check("nobyp settled data", nb_radata, 32'h44);
        check("nobyp settled busy", {31'd0, nb_busy_a}, 0);
        next_cycle();

        // reset mid-operation with a write pending on r5; r9 is busy
        drive(mk(5, 9, 5, 0, 0, 1, 32'h1, 0, 0, 0, 0, 0, 0));
        #1;
        check("pre-rst busy_b", {31'd0, busy_b}, 1);
        #1;
        reset_n = 1'b0;
        #1;
        check("midrst radata", radata, 0);
        check("midrst rbdata", rbdata, 0);
        check("midrst busy_b", {31'd0, busy_b}, 0);
        check("midrst nb radata", nb_radata, 0);
        next_cycle();
        @(negedge clock);
        werf = 1'b0;
        reset_n = 1'b1;
        #1;
        check("postrst r5", radata, 0);
        check("postrst r9 data", rbdata, 0);
        check("postrst r9 busy", {31'd0, busy_b}, 0);
        ra = 30;
        #1;
        check("postrst r30", radata, 0);
        next_cycle();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
